// File: rtl/serial_rx_controller_if.sv
//==============================================================================
// serial_rx_controller_if : line, BitCounter and host signals of the serial RX FSM
// Rev 1.0
//==============================================================================
`default_nettype none

interface serial_rx_controller_if;
    logic       SerialIn;
    logic [7:0] Count;
    logic       ClearCounter;
    logic       IncCounter;
    logic       ShiftEn;
    logic       RxBit;
    logic       DataValid;
    logic       FrameError;
    logic       Busy;

    modport master (
        input  SerialIn, Count,
        output ClearCounter, IncCounter, ShiftEn, RxBit, DataValid, FrameError, Busy
    );

    modport slave (
        output SerialIn, Count,
        input  ClearCounter, IncCounter, ShiftEn, RxBit, DataValid, FrameError, Busy
    );
endinterface

`default_nettype wire

// File: rtl/serial_rx_controller.sv
//==============================================================================
// serial_rx_controller : sequences one start/data/stop serial frame
// Rev 1.0
//==============================================================================
`default_nettype none

module serial_rx_controller #(
    parameter int DATA_BITS    = 8,
    parameter int BIT_PERIOD   = 16,
    parameter int SAMPLE_POINT = 8
) (
    input wire logic                   clk,
    input wire logic                   reset,
    serial_rx_controller_if.master     bus
);

    localparam int              TW            = $clog2(BIT_PERIOD);
    localparam logic [TW-1:0]   c_tick_last   = TW'(BIT_PERIOD - 1);
    localparam logic [TW-1:0]   c_tick_sample = TW'(SAMPLE_POINT);
    localparam logic [7:0]      c_data_bits   = 8'(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic            rx_meta_q, rx_s_q;
    logic            clear_q, clear_d;
    logic            inc_q, inc_d;
    logic            shift_q, shift_d;
    logic            rxbit_q, rxbit_d;
    logic            dv_q, dv_d;
    logic            fe_q, fe_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            clear_q   <= 1'b1;
            inc_q     <= 1'b0;
            shift_q   <= 1'b0;
            rxbit_q   <= 1'b0;
            dv_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            rx_meta_q <= bus.SerialIn;
            rx_s_q    <= rx_meta_q;
            clear_q   <= clear_d;
            inc_q     <= inc_d;
            shift_q   <= shift_d;
            rxbit_q   <= rxbit_d;
            dv_q      <= dv_d;
            fe_q      <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        inc_d   = 1'b0;
        shift_d = 1'b0;
        rxbit_d = rxbit_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (tick_q == c_tick_sample && rx_s_q) state_d = S_IDLE;
                else if (tick_q == c_tick_last)       state_d = S_DATA;
            end
            S_DATA: begin
                if (tick_q == c_tick_sample) begin
                    shift_d = 1'b1;
                    inc_d   = 1'b1;
                    rxbit_d = rx_s_q;
                end
                if (tick_q == c_tick_last && bus.Count >= c_data_bits) state_d = S_STOP;
            end
            S_STOP: begin
                if (tick_q == c_tick_sample) begin
                    if (rx_s_q) begin
                        dv_d    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The counter is held clear everywhere outside the data and stop phases.
        clear_d = (state_d == S_IDLE) || (state_d == S_START) || (state_d == S_BREAK);

        if (state_d != state_q || tick_q == c_tick_last) tick_d = '0;
        else                                             tick_d = tick_q + TW'(1);
    end

    assign bus.ClearCounter = clear_q;
    assign bus.IncCounter   = inc_q;
    assign bus.ShiftEn      = shift_q;
    assign bus.RxBit        = rxbit_q;
    assign bus.DataValid    = dv_q;
    assign bus.FrameError   = fe_q;
    assign bus.Busy         = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_rx_controller.sv
//==============================================================================
// tb_serial_rx_controller : randomized self-checking bench with BitCounter model
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_serial_rx_controller;

    localparam int DATA_BITS    = 8;
    localparam int BIT_PERIOD   = 16;
    localparam int SAMPLE_POINT = 8;
    localparam int FRAME_LAT    = (DATA_BITS + 1) * BIT_PERIOD + SAMPLE_POINT + 1;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] cnt_model = 8'd0;

    serial_rx_controller_if bus();

    serial_rx_controller #(
        .DATA_BITS   (DATA_BITS),
        .BIT_PERIOD  (BIT_PERIOD),
        .SAMPLE_POINT(SAMPLE_POINT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Behavioural BitCounter: updates one cycle after a clear or increment request.
    assign bus.Count = cnt_model;
    always @(posedge clk) begin
        if (bus.ClearCounter)    cnt_model <= 8'd0;
        else if (bus.IncCounter) cnt_model <= cnt_model + 8'd1;
    end

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_rise = 0;
    int   busy_len = 0;
    logic prev_busy = 1'b0;
    int   shift_cnt = 0;
    int   inc_cnt = 0;
    int   dv_cnt = 0;
    int   fe_cnt = 0;
    logic got_bits[$];
    int   lat_q[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.Busy && !prev_busy) busy_rise = cyc;
        if (!bus.Busy && prev_busy) busy_len = cyc - busy_rise;
        prev_busy = bus.Busy;
        if (bus.ShiftEn) begin
            shift_cnt++;
            got_bits.push_back(bus.RxBit);
        end
        if (bus.IncCounter) inc_cnt++;
        if (bus.DataValid) begin
            dv_cnt++;
            lat_q.push_back(cyc - busy_rise);
        end
        if (bus.FrameError) fe_cnt++;
        checks++;
        if ((bus.IncCounter & bus.ClearCounter) !== 1'b0 || bus.ShiftEn !== bus.IncCounter) begin
            errors++;
            $display("FAIL strobe_invariant cyc=%0d inc=%b clr=%b shift=%b (need !(inc&clr), shift==inc)",
                     cyc, bus.IncCounter, bus.ClearCounter, bus.ShiftEn);
        end
    end

    task automatic clear_stats();
        shift_cnt = 0;
        inc_cnt   = 0;
        dv_cnt    = 0;
        fe_cnt    = 0;
        busy_len  = 0;
        got_bits.delete();
        lat_q.delete();
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase.
    task automatic hold(input logic v, input int n);
        bus.SerialIn = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input int stop_cycles, input logic stop_val);
        hold(1'b0, BIT_PERIOD);
        for (int i = 0; i < DATA_BITS; i++) hold(data[i], BIT_PERIOD);
        hold(stop_val, stop_cycles);
    endtask

    // Reassemble received bits LSB first into a word; missing bits become X.
    function automatic logic [7:0] word_at(input int base);
        logic [7:0] w;
        for (int i = 0; i < 8; i++)
            w[i] = (base + i < got_bits.size()) ? got_bits[base + i] : 1'bx;
        return w;
    endfunction

    task automatic test_reset();
        bus.SerialIn = 1'b1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.ClearCounter, bus.IncCounter, bus.ShiftEn, bus.RxBit, bus.DataValid, bus.FrameError, bus.Busy} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_outputs got=%b need=1000000",
                     {bus.ClearCounter, bus.IncCounter, bus.ShiftEn, bus.RxBit, bus.DataValid, bus.FrameError, bus.Busy});
        end
        reset = 1'b1;
        hold(1'b1, 5);
        checks++;
        if ({bus.ClearCounter, bus.IncCounter, bus.ShiftEn, bus.DataValid, bus.FrameError, bus.Busy, bus.Count} !== {6'b100000, 8'd0}) begin
            errors++;
            $display("FAIL idle_outputs got=%b need=%b",
                     {bus.ClearCounter, bus.IncCounter, bus.ShiftEn, bus.DataValid, bus.FrameError, bus.Busy, bus.Count}, {6'b100000, 8'd0});
        end
    endtask

    task automatic test_frame_a5();
        clear_stats();
        send_frame(8'hA5, BIT_PERIOD, 1'b1);
        hold(1'b1, 20);
        checks++;
        if (shift_cnt !== 8) begin errors++; $display("FAIL a5_shift_count got=%0d need=8", shift_cnt); end
        checks++;
        if (word_at(0) !== 8'hA5) begin errors++; $display("FAIL a5_bits got=%h need=a5", word_at(0)); end
        checks++;
        if (dv_cnt !== 1 || fe_cnt !== 0) begin errors++; $display("FAIL a5_pulses dv=%0d fe=%0d need dv=1 fe=0", dv_cnt, fe_cnt); end
        checks++;
        if (lat_q.size() != 1 || lat_q[0] !== FRAME_LAT) begin
            errors++;
            $display("FAIL a5_latency got=%0d need=%0d", (lat_q.size() > 0) ? lat_q[0] : -1, FRAME_LAT);
        end
    endtask

    task automatic test_glitch();
        clear_stats();
        hold(1'b0, 5);
        hold(1'b1, 30);
        checks++;
        if (busy_len !== SAMPLE_POINT + 1) begin errors++; $display("FAIL glitch_busy_len got=%0d need=%0d", busy_len, SAMPLE_POINT + 1); end
        checks++;
        if (shift_cnt !== 0 || inc_cnt !== 0 || dv_cnt !== 0 || fe_cnt !== 0) begin
            errors++;
            $display("FAIL glitch_strobes shift=%0d inc=%0d dv=%0d fe=%0d need all 0", shift_cnt, inc_cnt, dv_cnt, fe_cnt);
        end
    endtask

    task automatic test_break();
        clear_stats();
        send_frame(8'h3C, 40, 1'b0);
        checks++;
        if (bus.Busy !== 1'b1 || fe_cnt !== 1 || dv_cnt !== 0) begin
            errors++;
            $display("FAIL break_hold busy=%b fe=%0d dv=%0d need busy=1 fe=1 dv=0", bus.Busy, fe_cnt, dv_cnt);
        end
        hold(1'b1, 10);
        checks++;
        if (bus.Busy !== 1'b0) begin errors++; $display("FAIL break_release busy=%b need 0", bus.Busy); end
        checks++;
        if (word_at(0) !== 8'h3C || shift_cnt !== 8 || fe_cnt !== 1 || dv_cnt !== 0) begin
            errors++;
            $display("FAIL break_frame bits=%h shift=%0d fe=%0d dv=%0d need 3c/8/1/0", word_at(0), shift_cnt, fe_cnt, dv_cnt);
        end
    endtask

    task automatic test_reset_mid_data();
        clear_stats();
        hold(1'b0, BIT_PERIOD);
        hold(1'b1, BIT_PERIOD);
        hold(1'b0, BIT_PERIOD);
        hold(1'b1, BIT_PERIOD);
        hold(1'b1, 4);
        checks++;
        if (shift_cnt !== 3) begin errors++; $display("FAIL midreset_pre_shifts got=%0d need=3", shift_cnt); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus.Busy, bus.ClearCounter} !== 2'b01) begin
            errors++;
            $display("FAIL midreset_async busy=%b clr=%b need busy=0 clr=1", bus.Busy, bus.ClearCounter);
        end
        bus.SerialIn = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        hold(1'b1, 10);
        checks++;
        if (dv_cnt !== 0 || fe_cnt !== 0) begin errors++; $display("FAIL midreset_no_pulse dv=%0d fe=%0d need 0", dv_cnt, fe_cnt); end
        clear_stats();
        send_frame(8'hFF, BIT_PERIOD, 1'b1);
        hold(1'b1, 20);
        checks++;
        if (dv_cnt !== 1 || shift_cnt !== 8 || word_at(0) !== 8'hFF) begin
            errors++;
            $display("FAIL midreset_next_frame dv=%0d shift=%0d bits=%h need 1/8/ff", dv_cnt, shift_cnt, word_at(0));
        end
    endtask

    task automatic test_back_to_back();
        clear_stats();
        send_frame(8'h01, BIT_PERIOD, 1'b1);
        checks++;
        if (bus.Count !== 8'd0) begin errors++; $display("FAIL b2b_count_cleared got=%0d need=0", bus.Count); end
        send_frame(8'h80, BIT_PERIOD, 1'b1);
        hold(1'b1, 20);
        checks++;
        if (dv_cnt !== 2 || shift_cnt !== 16) begin errors++; $display("FAIL b2b_counts dv=%0d shift=%0d need 2/16", dv_cnt, shift_cnt); end
        checks++;
        if (word_at(0) !== 8'h01 || word_at(8) !== 8'h80) begin
            errors++;
            $display("FAIL b2b_bits got=%h,%h need 01,80", word_at(0), word_at(8));
        end
        checks++;
        if (lat_q.size() != 2 || lat_q[0] !== FRAME_LAT || lat_q[1] !== FRAME_LAT) begin
            errors++;
            $display("FAIL b2b_latency n=%0d need two of %0d", lat_q.size(), FRAME_LAT);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_words[$];
        int         exp_dv = 0;
        int         exp_fe = 0;
        clear_stats();
        for (int f = 0; f < 6; f++) begin
            logic [7:0] data;
            int         gap;
            logic       bad;
            data = 8'($urandom_range(0, 255));
            gap  = $urandom_range(0, 20);
            bad  = ($urandom_range(0, 3) == 0);
            exp_words.push_back(data);
            if (bad) begin
                send_frame(data, 30, 1'b0);
                hold(1'b1, gap + 3);
                exp_fe++;
            end else begin
                send_frame(data, BIT_PERIOD, 1'b1);
                if (gap > 0) hold(1'b1, gap);
                exp_dv++;
            end
        end
        hold(1'b1, 30);
        checks++;
        if (dv_cnt !== exp_dv || fe_cnt !== exp_fe || shift_cnt !== 6 * DATA_BITS) begin
            errors++;
            $display("FAIL rand_counts dv=%0d fe=%0d shift=%0d need %0d/%0d/%0d", dv_cnt, fe_cnt, shift_cnt, exp_dv, exp_fe, 6 * DATA_BITS);
        end
        foreach (exp_words[f]) begin
            checks++;
            if (word_at(f * DATA_BITS) !== exp_words[f]) begin
                errors++;
                $display("FAIL rand_word%0d got=%h need=%h", f, word_at(f * DATA_BITS), exp_words[f]);
            end
        end
        foreach (lat_q[i]) begin
            checks++;
            if (lat_q[i] !== FRAME_LAT) begin errors++; $display("FAIL rand_latency%0d got=%0d need=%0d", i, lat_q[i], FRAME_LAT); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_frame_a5();
        test_glitch();
        test_break();
        test_reset_mid_data();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
